// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uart_pkg
// Brief    : Shared UART definitions (state encoding, frame constants),
//            common to the transmit stimulus and the receive monitor.
// Revision : 1.0 - initial release
// ============================================================================
package uart_pkg;

  localparam int DATA_BITS            = 8;
  localparam int CLKS_PER_BIT_DEFAULT = 434;  // 100 MHz / 230400 baud

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } uart_state_t;

endpackage
`default_nettype wire

// File: rtl/uart_tx_fifo.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_fifo
// Brief    : Synchronous FIFO; extra pointer MSB separates full from empty,
//            occupancy kept in a registered count.
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] i_wr_data,
  input  logic             i_wr_en,
  input  logic             i_rd_en,
  output logic [WIDTH-1:0] o_rd_data,
  output logic             o_full,
  output logic             o_empty,
  output logic [$clog2(DEPTH):0] o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] c_one = (AW+1)'(1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_push;
  logic             w_pop;

  // A full FIFO stalls writes even when a read happens the same cycle.
  assign w_push = i_wr_en && !o_full;
  assign w_pop  = i_rd_en && !o_empty;

  assign o_empty   = (r_wr_ptr == r_rd_ptr);
  assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign o_rd_data = r_mem[r_rd_ptr[AW-1:0]];
  assign o_count   = r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + c_one;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + c_one;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + c_one;
        2'b01:   r_count <= r_count - c_one;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= i_wr_data;
  end

endmodule
`default_nettype wire

// File: rtl/uart_tx_stim.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_stim
// Brief    : 8N1 UART transmitter with input byte FIFO for rxd stimulus.
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx_stim
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic       clock,
  input  logic       reset_rtl,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic       txd,
  output logic       busy,
  output logic       tx_done
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(DATA_BITS);
  localparam logic [CW-1:0] c_last_cnt = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] c_cnt_one  = CW'(1);
  localparam logic [BW-1:0] c_last_bit = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0] c_bit_one  = BW'(1);

  uart_state_t          r_state;
  uart_state_t          w_state_nxt;
  logic [CW-1:0]        r_cnt;
  logic [CW-1:0]        w_cnt_nxt;
  logic [BW-1:0]        r_bit_idx;
  logic [BW-1:0]        w_bit_nxt;
  logic [DATA_BITS-1:0] r_shift;
  logic [DATA_BITS-1:0] w_shift_nxt;
  logic                 r_txd;
  logic                 w_txd_nxt;
  logic                 r_done;
  logic                 w_done_nxt;
  logic                 r_busy;
  logic                 w_pop;

  logic [DATA_BITS-1:0]        w_fifo_data;
  logic                        w_fifo_full;
  logic                        w_fifo_empty;
  logic [$clog2(FIFO_DEPTH):0] w_fifo_count;

  uart_tx_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clock),
    .rst_n     (reset_rtl),
    .i_wr_data (in_data),
    .i_wr_en   (in_valid),
    .i_rd_en   (w_pop),
    .o_rd_data (w_fifo_data),
    .o_full    (w_fifo_full),
    .o_empty   (w_fifo_empty),
    .o_count   (w_fifo_count)
  );

  assign in_ready = !w_fifo_full;
  assign txd      = r_txd;
  assign busy     = r_busy;
  assign tx_done  = r_done;

  always_ff @(posedge clock or negedge reset_rtl) begin
    if (!reset_rtl) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_bit_idx <= '0;
      r_shift   <= '0;
      r_txd     <= 1'b1;
      r_done    <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_bit_idx <= w_bit_nxt;
      r_shift   <= w_shift_nxt;
      r_txd     <= w_txd_nxt;
      r_done    <= w_done_nxt;
      r_busy    <= (w_state_nxt != ST_IDLE) || (w_fifo_count != '0);
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_bit_nxt   = r_bit_idx;
    w_shift_nxt = r_shift;
    w_txd_nxt   = r_txd;
    w_done_nxt  = 1'b0;
    w_pop       = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (!w_fifo_empty) begin
          w_pop       = 1'b1;
          w_shift_nxt = w_fifo_data;
          w_txd_nxt   = 1'b0;
          w_cnt_nxt   = '0;
          w_state_nxt = ST_START;
        end else begin
          w_txd_nxt   = 1'b1;
        end
      end

      ST_START: begin
        if (r_cnt == c_last_cnt) begin
          w_cnt_nxt   = '0;
          w_txd_nxt   = r_shift[0];
          w_bit_nxt   = '0;
          w_state_nxt = ST_DATA;
        end else begin
          w_cnt_nxt   = r_cnt + c_cnt_one;
        end
      end

      ST_DATA: begin
        if (r_cnt == c_last_cnt) begin
          w_cnt_nxt = '0;
          if (r_bit_idx != c_last_bit) begin
            w_bit_nxt   = r_bit_idx + c_bit_one;
            w_shift_nxt = {1'b0, r_shift[DATA_BITS-1:1]};
            w_txd_nxt   = r_shift[1];
          end else begin
            w_txd_nxt   = 1'b1;
            w_state_nxt = ST_STOP;
          end
        end else begin
          w_cnt_nxt = r_cnt + c_cnt_one;
        end
      end

      ST_STOP: begin
        if (r_cnt == c_last_cnt) begin
          w_cnt_nxt  = '0;
          w_done_nxt = 1'b1;
          // Chain straight into the next start bit so queued bytes leave no gap.
          if (!w_fifo_empty) begin
            w_pop       = 1'b1;
            w_shift_nxt = w_fifo_data;
            w_txd_nxt   = 1'b0;
            w_state_nxt = ST_START;
          end else begin
            w_txd_nxt   = 1'b1;
            w_state_nxt = ST_IDLE;
          end
        end else begin
          w_cnt_nxt = r_cnt + c_cnt_one;
        end
      end

      default: begin
        w_state_nxt = ST_IDLE;
        w_txd_nxt   = 1'b1;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_stim.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx_stim
// Brief    : Self-checking bench: frame-level reference model plus loopback
//            receiver for uart_tx_stim.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_tx_stim;

  localparam int CPB   = 4;
  localparam int DEPTH = 4;
  localparam int CPB_D = 434;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_valid = 1'b0;
  wire        in_ready, txd, busy, tx_done;

  logic [7:0] in_data_d = 8'h00;
  logic       in_valid_d = 1'b0;
  wire        in_ready_d, txd_d, busy_d, tx_done_d;

  always #5 clk = ~clk;

  uart_tx_stim #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .clock(clk), .reset_rtl(rst_n), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .txd(txd), .busy(busy), .tx_done(tx_done));

  uart_tx_stim #(.CLKS_PER_BIT(CPB_D), .FIFO_DEPTH(DEPTH)) dut_d (
    .clock(clk), .reset_rtl(rst_n), .in_data(in_data_d), .in_valid(in_valid_d),
    .in_ready(in_ready_d), .txd(txd_d), .busy(busy_d), .tx_done(tx_done_d));

  int n_total = 0;
  int n_pass  = 0;
  int cyc     = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Reference model: frame timeline per accepted byte, queue for the FIFO.
  logic       m_active = 1'b0;
  int         m_start  = 0;
  logic [7:0] m_byte   = 8'h00;
  logic [7:0] mq[$];
  logic [7:0] sentq[$];
  logic [7:0] rxq[$];
  logic exp_txd = 1'b1, exp_done = 1'b0, exp_busy = 1'b0, exp_ready = 1'b1;

  task automatic model_step();
    int pre_size, pos, bitn;
    cyc++;
    if (!rst_n) begin
      mq.delete();
      m_active = 1'b0;
      exp_txd = 1'b1; exp_done = 1'b0; exp_busy = 1'b0; exp_ready = 1'b1;
      return;
    end
    pre_size = mq.size();
    exp_done = 1'b0;
    if (m_active && (cyc - m_start == 10 * CPB)) begin
      exp_done = 1'b1;
      m_active = 1'b0;
    end
    if (!m_active && pre_size > 0) begin
      m_byte   = mq.pop_front();
      m_active = 1'b1;
      m_start  = cyc;
    end
    if (in_valid && pre_size < DEPTH) begin
      mq.push_back(in_data);
      sentq.push_back(in_data);
    end
    exp_txd = 1'b1;
    if (m_active) begin
      pos  = cyc - m_start;
      bitn = pos / CPB;
      if (bitn == 0) exp_txd = 1'b0;
      else if (bitn <= 8) exp_txd = m_byte[bitn-1];
    end
    exp_busy  = m_active;
    exp_ready = (mq.size() < DEPTH);
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      check("reset_txd", txd, 1); check("reset_busy", busy, 0);
      check("reset_done", tx_done, 0); check("reset_ready", in_ready, 1);
    end else begin
      check("txd", txd, exp_txd); check("busy", busy, exp_busy);
      check("tx_done", tx_done, exp_done); check("in_ready", in_ready, exp_ready);
    end
  end

  // Loopback receiver: mid-bit sampling from the detected start edge.
  logic       rx_active = 1'b0;
  int         rx_s = 0;
  logic [7:0] rx_b = 8'h00;
  initial forever begin
    int off;
    @(negedge clk);
    if (!rst_n) rx_active = 1'b0;
    else if (!rx_active) begin
      if (txd == 1'b0) begin rx_active = 1'b1; rx_s = cyc; rx_b = 8'h00; end
    end else begin
      off = cyc - rx_s;
      if (off == CPB / 2) check("rx_start_bit", txd, 0);
      for (int i = 0; i < 8; i++)
        if (off == CPB * (i + 1) + CPB / 2) rx_b[i] = txd;
      if (off == 9 * CPB + CPB / 2) begin
        check("rx_stop_bit", txd, 1);
        rxq.push_back(rx_b);
        rx_active = 1'b0;
      end
    end
  end

  task automatic push(input logic [7:0] d, output int e);
    in_valid = 1'b1; in_data = d;
    @(posedge clk); #1;
    in_valid = 1'b0;
    e = cyc;
  endtask

  task automatic wait_cyc(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic drain(input int n, input int bound);
    int k = 0;
    while ((rxq.size() < n || busy) && k < bound) begin @(negedge clk); k++; end
    check("drain_in_time", (k < bound), 1);
  endtask

  task automatic compare_rx(input string name);
    check({name, "_count"}, rxq.size(), sentq.size());
    for (int i = 0; i < rxq.size() && i < sentq.size(); i++)
      check({name, "_byte"}, rxq[i], sentq[i]);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached, got %0d/%0d", n_pass, n_total);
    $fatal(1, "watchdog");
  end

  initial begin
    int e, done_at, first_block, idx, tcount, zeros;
    int done_d[$];
    logic [9:0] pat;
    logic [7:0] full_list[6];
    logic [7:0] dec[2];
    logic prev;

    repeat (3) @(posedge clk);
    #1;
    check("init_txd", txd, 1); check("init_busy", busy, 0);
    check("init_done", tx_done, 0); check("init_ready", in_ready, 1);
    rst_n = 1'b1;

    // Idle stability
    tcount = 0; zeros = 0;
    repeat (5000) begin
      @(negedge clk);
      if (tx_done) tcount++;
      if (!txd) zeros++;
    end
    check("idle_done_pulses", tcount, 0);
    check("idle_txd_low_cycles", zeros, 0);

    // Single byte 0x55
    sentq.delete(); rxq.delete();
    pat = 10'b10_1010_1010;
    push(8'h55, e);
    @(negedge clk);
    check("txd_high_at_accept", txd, 1);
    done_at = -1;
    for (int off = 1; off <= 44; off++) begin
      @(negedge clk);
      if (off == 1) check("txd_fall_E+1", txd, 0);
      if (off >= 3 && (off - 3) % 4 == 0 && (off - 3) / 4 < 10)
        check("midbit_0x55", txd, pat[(off - 3) / 4]);
      if (tx_done && done_at < 0) done_at = off;
    end
    check("tx_done_at_E+41", done_at, 41);
    drain(1, 200);
    compare_rx("single");

    // Back-to-back 0xA3, 0x0F
    sentq.delete(); rxq.delete();
    in_valid = 1'b1; in_data = 8'hA3;
    @(posedge clk); #1;
    e = cyc;
    in_data = 8'h0F;
    @(posedge clk); #1;
    in_valid = 1'b0;
    done_d.delete();
    while (cyc < e + 85) begin
      @(negedge clk);
      if (tx_done) done_d.push_back(cyc - e);
      if (cyc == e + 41) check("b2b_no_gap_start", txd, 0);
    end
    check("b2b_done_count", done_d.size(), 2);
    if (done_d.size() == 2) begin
      check("b2b_done1", done_d[0], 41);
      check("b2b_done2", done_d[1], 81);
    end
    drain(2, 200);
    check("b2b_rx0", rxq.size() > 0 ? rxq[0] : 8'hxx, 8'hA3);
    check("b2b_rx1", rxq.size() > 1 ? rxq[1] : 8'hxx, 8'h0F);

    // FIFO full: hold in_valid high with 6 bytes
    sentq.delete(); rxq.delete();
    full_list = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    idx = 0; first_block = -1; tcount = 0;
    while (idx < 6 && tcount < 2000) begin
      logic rdy;
      in_valid = 1'b1; in_data = full_list[idx];
      rdy = in_ready;
      @(posedge clk); #1;
      if (rdy) idx++;
      else if (first_block < 0) first_block = idx;
      tcount++;
    end
    in_valid = 1'b0;
    check("full_all_accepted", idx, 6);
    check("full_block_after", first_block, 5);
    drain(6, 600);
    compare_rx("full");
    for (int i = 0; i < 6 && i < rxq.size(); i++) check("full_order", rxq[i], full_list[i]);

    // Randomised traffic
    sentq.delete(); rxq.delete();
    repeat (300) begin
      in_valid = ($urandom_range(0, 2) == 0);
      in_data  = 8'($urandom);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    drain(sentq.size(), 2000);
    compare_rx("random");

    // Reset during data bit 3 of 0xFF
    sentq.delete(); rxq.delete();
    push(8'hFF, e);
    wait_cyc(e + 18);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("midrst_txd", txd, 1); check("midrst_busy", busy, 0);
    check("midrst_ready", in_ready, 1); check("midrst_done", tx_done, 0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    sentq.delete(); rxq.delete();
    repeat (20) @(negedge clk);
    check("postrst_no_frame", rxq.size(), 0);
    @(posedge clk); #1;
    push(8'h41, e);
    drain(1, 200);
    check("postrst_count", rxq.size(), 1);
    check("postrst_byte", rxq.size() > 0 ? rxq[0] : 8'hxx, 8'h41);

    // Default timing, ASCII "OK"
    check("d_ready", in_ready_d, 1); check("d_busy", busy_d, 0); check("d_txd", txd_d, 1);
    in_valid_d = 1'b1; in_data_d = 8'h4F;
    @(posedge clk); #1;
    e = cyc;
    in_data_d = 8'h4B;
    @(posedge clk); #1;
    in_valid_d = 1'b0;
    prev = 1'b1; done_d.delete(); dec[0] = 8'h00; dec[1] = 8'h00;
    while (cyc < e + 20 * CPB_D + 5) begin
      int t, j;
      @(negedge clk);
      t = cyc - e;
      if (txd_d != prev) check("d_bit_period", (t - 1) % CPB_D, 0);
      prev = txd_d;
      if (tx_done_d) done_d.push_back(t);
      if (t >= 1 + CPB_D / 2 && (t - 1 - CPB_D / 2) % CPB_D == 0 && (t - 1) / CPB_D < 20) begin
        j = (t - 1) / CPB_D;
        if (j % 10 == 0) check("d_start_bit", txd_d, 0);
        else if (j % 10 == 9) check("d_stop_bit", txd_d, 1);
        else dec[j / 10][(j % 10) - 1] = txd_d;
      end
    end
    $display("bench receiver: %c%c", dec[0], dec[1]);
    check("d_rx_O", dec[0], 8'h4F);
    check("d_rx_K", dec[1], 8'h4B);
    check("d_done_count", done_d.size(), 2);
    if (done_d.size() == 2) begin
      check("d_done1", done_d[0], 10 * CPB_D + 1);
      check("d_done2", done_d[1], 20 * CPB_D + 1);
    end
    @(negedge clk);
    check("d_busy_end", busy_d, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
